// File: rtl/sw_port_regs.sv
// sw_port_regs: per-switch register slave with four port-configuration registers.
// It serves the decoder's select/address/data/direction bus and answers every
// request with a one-cycle ack. Register contents are exposed flat on cfg_flat.
// Optional build macro SW_REG_LOCK_EN: bit 0 of reg3 locks regs 0..2 and adds
// the lock_err output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for sel_en; writes and zero-delay reads complete here
// RD_WAIT | read captured, down-counter running toward terminal count 0
// ACK     | ack_out high for this single cycle, then back to IDLE
module sw_port_regs #(
  parameter int                 W_WIDTH     = 8,
  parameter int                 READ_DELAY  = 1,
  parameter logic [W_WIDTH-1:0] REG_RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel_en,
  input  logic [1:0]             addr,
  input  logic [W_WIDTH-1:0]     wr_data,
  input  logic                   wr_rd_s,
  input  logic                   err_clr,
  output logic [W_WIDTH-1:0]     rd_data_out,
  output logic                   ack_out,
  output logic                   busy_out,
  output logic                   ovr_err,
`ifdef SW_REG_LOCK_EN
  output logic                   lock_err,
`endif
  output logic [4*W_WIDTH-1:0]   cfg_flat
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  // A zero read delay completes straight from IDLE, so the counter is never
  // loaded in that build and the load value is clamped to keep it in range.
  localparam bit         RD_NODELAY = (READ_DELAY == 0);
  localparam logic [3:0] CNT_LOAD   = RD_NODELAY ? 4'd0 : 4'(READ_DELAY - 1);

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic [1:0]         rd_addr;
  logic [W_WIDTH-1:0] regs [4];

  logic req_wr;
  logic req_rd;
  logic overrun;
  logic wr_blocked;
  logic rd_done;
  logic [1:0] rd_sel_addr;

  assign req_wr  = (state == IDLE) && sel_en && wr_rd_s;
  assign req_rd  = (state == IDLE) && sel_en && !wr_rd_s;
  assign overrun = (state != IDLE) && sel_en;

`ifdef SW_REG_LOCK_EN
  // reg3 stays writable so software can always release the lock.
  assign wr_blocked = regs[3][0] && (addr != 2'd3);
`else
  assign wr_blocked = 1'b0;
`endif

  assign rd_done     = ((state == RD_WAIT) && (cnt == 4'd0)) || (req_rd && RD_NODELAY);
  assign rd_sel_addr = (state == RD_WAIT) ? rd_addr : addr;

  assign cfg_flat = {regs[3], regs[2], regs[1], regs[0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_wr)      state_nxt = ACK;
        else if (req_rd) state_nxt = RD_NODELAY ? ACK : RD_WAIT;
      end
      RD_WAIT: if (cnt == 4'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    ack_out  = (state == ACK);
    busy_out = (state != IDLE);
  end

  // Read-delay down-counter and captured read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      rd_addr <= 2'd0;
    end else begin
      if (req_rd) rd_addr <= addr;
      if (req_rd && !RD_NODELAY)                 cnt <= CNT_LOAD;
      else if ((state == RD_WAIT) && (cnt != 0)) cnt <= cnt - 4'd1;
    end
  end

  // Register file write port and read data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_RST_VAL;
      rd_data_out <= '0;
    end else begin
      if (req_wr && !wr_blocked) regs[addr] <= wr_data;
      if (rd_done)               rd_data_out <= regs[rd_sel_addr];
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_err <= 1'b0;
    end else begin
      if (overrun)      ovr_err <= 1'b1;
      else if (err_clr) ovr_err <= 1'b0;
    end
  end

`ifdef SW_REG_LOCK_EN
  // Blocked-write flag, same set/clear priority as the overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_err <= 1'b0;
    end else begin
      if (req_wr && wr_blocked) lock_err <= 1'b1;
      else if (err_clr)         lock_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sw_port_regs.sv
// Bench for sw_port_regs: one instance with READ_DELAY=3 (dut3), one with
// READ_DELAY=0 (dut0). Expected acks are queued when a request is driven and
// popped when ack_out is seen. Lock tests build only with SW_REG_LOCK_EN.
module tb_sw_port_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel3 = 1'b0;
  logic       sel0 = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_rd_s = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0]  rd_data3, rd_data0;
  logic        ack3, ack0, busy3, busy0, ovr3, ovr0;
  logic [31:0] cfg3, cfg0;
`ifdef SW_REG_LOCK_EN
  logic        lock3, lock0;
`endif

  typedef struct {int cyc; logic [7:0] data; bit rd;} exp_t;
  exp_t q3[$];
  exp_t q0[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_ack3 = 0;
  int n_ack0 = 0;

  sw_port_regs #(.W_WIDTH(8), .READ_DELAY(3), .REG_RST_VAL(8'h00)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel3), .addr(addr), .wr_data(wr_data),
    .wr_rd_s(wr_rd_s), .err_clr(err_clr), .rd_data_out(rd_data3), .ack_out(ack3),
    .busy_out(busy3), .ovr_err(ovr3),
`ifdef SW_REG_LOCK_EN
    .lock_err(lock3),
`endif
    .cfg_flat(cfg3));

  sw_port_regs #(.W_WIDTH(8), .READ_DELAY(0), .REG_RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel0), .addr(addr), .wr_data(wr_data),
    .wr_rd_s(wr_rd_s), .err_clr(err_clr), .rd_data_out(rd_data0), .ack_out(ack0),
    .busy_out(busy0), .ovr_err(ovr0),
`ifdef SW_REG_LOCK_EN
    .lock_err(lock0),
`endif
    .cfg_flat(cfg0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ack3 === 1'b1) n_ack3 <= n_ack3 + 1;
    if (ack0 === 1'b1) n_ack0 <= n_ack0 + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Drives one request; cycle T is returned. Deassertion is left to the caller.
  task automatic issue(input bit to0, input bit wr, input logic [1:0] a,
                       input logic [7:0] d, output int t);
    @(posedge clk); #1;
    addr = a; wr_data = d; wr_rd_s = wr;
    if (to0) sel0 = 1'b1; else sel3 = 1'b1;
    t = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack3 !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b/%b exp=0/0", ack3, ack0); end
    checks++; if (busy3 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy3, busy0); end
    checks++; if (ovr3 !== 1'b0 || ovr0 !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b/%b exp=0/0", ovr3, ovr0); end
    checks++; if (rd_data3 !== 8'h00 || rd_data0 !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h/%h exp=00/00", rd_data3, rd_data0); end
    checks++; if (cfg3 !== 32'h0 || cfg0 !== 32'h0) begin failures++; $display("FAIL reset_cfg got=%h/%h exp=0/0", cfg3, cfg0); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_write();
    int t, a0;
    exp_t e;
    issue(1'b0, 1'b1, 2'd2, 8'hA5, t);
    q3.push_back('{cyc: t + 1, data: 8'h00, rd: 1'b0});
    a0 = n_ack3;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1 sel3 = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        checks++; if (cfg3[23:16] !== 8'hA5) begin failures++; $display("FAIL write_cfg got=%h exp=a5", cfg3[23:16]); end
      end
      if (ack3 === 1'b1) begin
        checks++;
        if (q3.size() == 0) begin failures++; $display("FAIL write_spurious_ack cyc=%0d", cyc); end
        else begin
          e = q3.pop_front();
          if (cyc !== e.cyc) begin failures++; $display("FAIL write_ack_cycle got=%0d exp=%0d", cyc, e.cyc); end
        end
      end
    end
    #1;
    checks++; if (q3.size() != 0) begin failures++; $display("FAIL write_missing_ack pending=%0d exp=0", q3.size()); q3.delete(); end
    checks++; if (n_ack3 - a0 != 1) begin failures++; $display("FAIL write_ack_count got=%0d exp=1", n_ack3 - a0); end
    checks++; if (rd_data3 !== 8'h00) begin failures++; $display("FAIL write_rd_data_touched got=%h exp=00", rd_data3); end
  endtask

  task automatic test_read_delay();
    int t, a0;
    logic exp_busy;
    exp_t e;
    issue(1'b0, 1'b0, 2'd2, 8'h00, t);
    q3.push_back('{cyc: t + 4, data: 8'hA5, rd: 1'b1});
    a0 = n_ack3;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 sel3 = 1'b0;
      @(negedge clk);
      exp_busy = (cyc >= t + 1) && (cyc <= t + 4);
      checks++; if (busy3 !== exp_busy) begin failures++; $display("FAIL rd_busy cyc=%0d got=%b exp=%b", cyc - t, busy3, exp_busy); end
      if (ack3 === 1'b1) begin
        checks++;
        if (q3.size() == 0) begin failures++; $display("FAIL rd_spurious_ack cyc=%0d", cyc); end
        else begin
          e = q3.pop_front();
          if (cyc !== e.cyc) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=%0d", cyc, e.cyc); end
          checks++; if (rd_data3 !== e.data) begin failures++; $display("FAIL rd_data got=%h exp=%h", rd_data3, e.data); end
        end
      end
    end
    #1;
    checks++; if (q3.size() != 0) begin failures++; $display("FAIL rd_missing_ack pending=%0d exp=0", q3.size()); q3.delete(); end
    checks++; if (n_ack3 - a0 != 1) begin failures++; $display("FAIL rd_ack_count got=%0d exp=1", n_ack3 - a0); end
    checks++; if (rd_data3 !== 8'hA5) begin failures++; $display("FAIL rd_data_held got=%h exp=a5", rd_data3); end
  endtask

  task automatic test_read_zero_delay();
    int t, a0;
    exp_t e;
    a0 = n_ack0;
    for (int n = 0; n < 2; n++) begin
      issue(1'b1, (n == 0), 2'd0, 8'h3C, t);
      q0.push_back('{cyc: t + 1, data: 8'h3C, rd: (n == 1)});
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1 sel0 = 1'b0;
        @(negedge clk);
        if (ack0 === 1'b1) begin
          checks++;
          if (q0.size() == 0) begin failures++; $display("FAIL rd0_spurious_ack cyc=%0d", cyc); end
          else begin
            e = q0.pop_front();
            if (cyc !== e.cyc) begin failures++; $display("FAIL rd0_ack_cycle got=%0d exp=%0d", cyc, e.cyc); end
            if (e.rd) begin
              checks++; if (rd_data0 !== e.data) begin failures++; $display("FAIL rd0_data got=%h exp=%h", rd_data0, e.data); end
            end
          end
        end
      end
    end
    #1;
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL rd0_missing_ack pending=%0d exp=0", q0.size()); q0.delete(); end
    checks++; if (n_ack0 - a0 != 2) begin failures++; $display("FAIL rd0_ack_count got=%0d exp=2", n_ack0 - a0); end
    checks++; if (cfg0[7:0] !== 8'h3C) begin failures++; $display("FAIL rd0_cfg got=%h exp=3c", cfg0[7:0]); end
  endtask

  task automatic test_overrun();
    int t, a0;
    exp_t e;
    checks++; if (ovr3 !== 1'b0) begin failures++; $display("FAIL ovr_initial got=%b exp=0", ovr3); end
    a0 = n_ack3;
    for (int n = 0; n < 2; n++) begin
      issue(1'b0, 1'b0, 2'd1, 8'h00, t);
      q3.push_back('{cyc: t + 4, data: 8'h00, rd: 1'b1});
      for (int k = 1; k <= 7; k++) begin
        @(posedge clk); #1;
        addr = 2'd1; wr_data = 8'h77; wr_rd_s = 1'b1;
        // First pass: intrusions in RD_WAIT and in ACK. Second pass: one with err_clr.
        sel3    = (n == 0) ? ((cyc == t + 2) || (cyc == t + 4)) : (cyc == t + 2);
        err_clr = (n == 1) && (cyc == t + 2);
        @(negedge clk);
        if (ack3 === 1'b1) begin
          checks++;
          if (q3.size() == 0) begin failures++; $display("FAIL ovr_spurious_ack cyc=%0d", cyc); end
          else begin
            e = q3.pop_front();
            if (cyc !== e.cyc) begin failures++; $display("FAIL ovr_ack_cycle got=%0d exp=%0d", cyc, e.cyc); end
            checks++; if (rd_data3 !== e.data) begin failures++; $display("FAIL ovr_rd_data got=%h exp=%h", rd_data3, e.data); end
          end
        end
      end
      checks++; if (ovr3 !== 1'b1) begin failures++; $display("FAIL ovr_set pass=%0d got=%b exp=1", n, ovr3); end
      if (n == 0) begin
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        checks++; if (ovr3 !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovr3); end
      end
    end
    #1;
    checks++; if (q3.size() != 0) begin failures++; $display("FAIL ovr_missing_ack pending=%0d exp=0", q3.size()); q3.delete(); end
    checks++; if (n_ack3 - a0 != 2) begin failures++; $display("FAIL ovr_ack_count got=%0d exp=2", n_ack3 - a0); end
    checks++; if (cfg3[15:8] !== 8'h00) begin failures++; $display("FAIL ovr_dropped_write got=%h exp=00", cfg3[15:8]); end
  endtask

  task automatic test_reset_mid_read();
    int t, a0;
    issue(1'b0, 1'b0, 2'd2, 8'h00, t);
    a0 = n_ack3;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      sel3 = 1'b0;
      if (cyc == t + 2) rst_n = 1'b0;
      if (cyc == t + 3) rst_n = 1'b1;
      @(negedge clk);
      if (cyc == t + 2) begin
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy3); end
      end
    end
    #1;
    checks++; if (n_ack3 - a0 != 0) begin failures++; $display("FAIL rst_mid_ack_count got=%0d exp=0", n_ack3 - a0); end
    checks++; if (busy3 !== 1'b0 || rd_data3 !== 8'h00) begin failures++; $display("FAIL rst_mid_idle busy=%b rd=%h exp=0/00", busy3, rd_data3); end
    checks++; if (cfg3 !== 32'h0) begin failures++; $display("FAIL rst_mid_cfg got=%h exp=0", cfg3); end
  endtask

`ifdef SW_REG_LOCK_EN
  task automatic test_lock();
    logic [1:0] ta [4];
    logic [7:0] td [4];
    int t;
    exp_t e;
    ta[0] = 2'd3; td[0] = 8'h01;
    ta[1] = 2'd1; td[1] = 8'hFF;
    ta[2] = 2'd3; td[2] = 8'h00;
    ta[3] = 2'd1; td[3] = 8'hFF;
    for (int n = 0; n < 4; n++) begin
      issue(1'b0, 1'b1, ta[n], td[n], t);
      q3.push_back('{cyc: t + 1, data: 8'h00, rd: 1'b0});
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1 sel3 = 1'b0;
        @(negedge clk);
        if (ack3 === 1'b1) begin
          checks++;
          if (q3.size() == 0) begin failures++; $display("FAIL lock_spurious_ack cyc=%0d", cyc); end
          else begin
            e = q3.pop_front();
            if (cyc !== e.cyc) begin failures++; $display("FAIL lock_ack_cycle got=%0d exp=%0d", cyc, e.cyc); end
          end
        end
      end
      checks++; if (q3.size() != 0) begin failures++; $display("FAIL lock_missing_ack step=%0d", n); q3.delete(); end
      if (n == 1) begin
        checks++; if (cfg3[15:8] !== 8'h00) begin failures++; $display("FAIL lock_blocked got=%h exp=00", cfg3[15:8]); end
        checks++; if (lock3 !== 1'b1) begin failures++; $display("FAIL lock_err_set got=%b exp=1", lock3); end
      end
      if (n == 3) begin
        checks++; if (cfg3[15:8] !== 8'hFF) begin failures++; $display("FAIL lock_released got=%h exp=ff", cfg3[15:8]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_delay();
    test_read_zero_delay();
    test_overrun();
    test_reset_mid_read();
`ifdef SW_REG_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
